// File: rtl/dff_link_4_circle_if.sv
// Data bundle for the recirculating DFF ring: load word, mode select and tail output.
// Master drives input_data/WR; the ring (slave) drives output_data. No handshake.
interface dff_link_4_circle_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] input_data;
  logic             WR;
  logic [WIDTH-1:0] output_data;

  modport master (
    output input_data,
    output WR,
    input  output_data
  );

  modport slave (
    input  input_data,
    input  WR,
    output output_data
  );
endinterface

// File: rtl/dff_link_4_circle.sv
// DEPTH-stage ring of WIDTH-bit registers: WR=1 shifts input_data in, WR=0 rotates tail to head.
// Advances every edge; a loaded word reaches output_data DEPTH-1 edges after its write. No backpressure.
module dff_link_4_circle #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic                CLK,
  input logic                RST,
  dff_link_4_circle_if.slave link
);

  logic [DEPTH-1:0][WIDTH-1:0] ring_q;
  logic [DEPTH-1:0][WIDTH-1:0] ring_d;

  // Head takes either the new word or the tail, so input_data is ignored while rotating.
  always_comb begin
    ring_d = ring_q;
    ring_d[0] = link.WR ? link.input_data : ring_q[DEPTH-1];
    for (int i = 1; i < DEPTH; i++) begin
      ring_d[i] = ring_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ring_q <= '0;
    end else begin
      ring_q <= ring_d;
    end
  end

  assign link.output_data = ring_q[DEPTH-1];

endmodule

// File: tb/tb_dff_link_4_circle.sv
// Randomised bench for the DFF ring: a default 8x4 instance and a 16x6 instance share clock and mode,
// each checked against a queue model where the back of the queue is the visible tail.
module tb_dff_link_4_circle;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dff_link_4_circle_if #(.WIDTH(8))  if_a ();
  dff_link_4_circle_if #(.WIDTH(16)) if_b ();

  dff_link_4_circle #(.WIDTH(8),  .DEPTH(4)) dut_a (.CLK(CLK), .RST(RST), .link(if_a.slave));
  dff_link_4_circle #(.WIDTH(16), .DEPTH(6)) dut_b (.CLK(CLK), .RST(RST), .link(if_b.slave));

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0]  q_a[$];
  logic [15:0] q_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the queue models, then compare both tails.
  task automatic step(input logic rst, input logic wr, input logic [7:0] da, input logic [15:0] db);
    logic [7:0]  ta;
    logic [15:0] tb;
    RST = rst;
    if_a.WR = wr;
    if_b.WR = wr;
    if_a.input_data = da;
    if_b.input_data = db;
    @(posedge CLK);
    if (rst) begin
      foreach (q_a[i]) q_a[i] = '0;
      foreach (q_b[i]) q_b[i] = '0;
    end else if (wr) begin
      q_a.push_front(da);
      ta = q_a.pop_back();
      q_b.push_front(db);
      tb = q_b.pop_back();
    end else begin
      ta = q_a.pop_back();
      q_a.push_front(ta);
      tb = q_b.pop_back();
      q_b.push_front(tb);
    end
    #1;
    check("a_tail", 32'(if_a.output_data), 32'(q_a[$]));
    check("b_tail", 32'(if_b.output_data), 32'(q_b[$]));
  endtask

  logic [7:0]  exp_pl[5];
  logic [15:0] first_b;
  logic [7:0]  hist_a[$];

  initial begin
    for (int i = 0; i < 4; i++) q_a.push_back('0);
    for (int i = 0; i < 6; i++) q_b.push_back('0);
    if_a.WR = 1'b1;
    if_b.WR = 1'b1;
    if_a.input_data = 8'hAA;
    if_b.input_data = 16'hAAAA;

    // Reset held two edges with WR=1 and busy data.
    repeat (2) step(1'b1, 1'b1, 8'hAA, 16'hAAAA);
    check("rst_out", 32'(if_a.output_data), 32'h0);
    repeat (4) begin
      step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
      check("rst_ring_zero", 32'(if_a.output_data), 32'h0);
    end

    // Counter-driven load 0..3 then rotate: 0,0,0,0 then 1,2,3,0,...
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'(i), 16'(i + 16'h100));
      check("load_out", 32'(if_a.output_data), 32'h0);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
      check("rot_out", 32'(if_a.output_data), 32'((i + 1) % 4));
    end

    // Partial load into ring {0,1,2,3}(head..tail is 3,2,1,0): write 8'h55 then rotate.
    exp_pl[0] = 8'h01; exp_pl[1] = 8'h02; exp_pl[2] = 8'h03; exp_pl[3] = 8'h55; exp_pl[4] = 8'h01;
    step(1'b0, 1'b1, 8'h55, 16'h5555);
    check("pl_0", 32'(if_a.output_data), 32'(exp_pl[0]));
    for (int i = 1; i < 5; i++) begin
      step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
      check("pl_rot", 32'(if_a.output_data), 32'(exp_pl[i]));
    end

    // Continuous write: output lags input by exactly 3 edges.
    hist_a.delete();
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'(8'h10 + i), 16'($urandom));
      hist_a.push_back(8'(8'h10 + i));
      if (i >= 3) check("lag3", 32'(if_a.output_data), 32'(hist_a[i-3]));
    end

    // Reset mid-rotation: load 1..4, rotate, one reset edge, ring stays zero.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 8'(i), 16'($urandom));
    repeat (2) step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
    step(1'b1, 1'b0, 8'($urandom), 16'($urandom));
    check("mid_rst", 32'(if_a.output_data), 32'h0);
    repeat (6) begin
      step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
      check("post_rst_zero", 32'(if_a.output_data), 32'h0);
    end

    // Wide/deep instance: 6-word load, first word after 6th write, period 6.
    step(1'b1, 1'b0, 8'h0, 16'h0);
    first_b = 16'($urandom) | 16'h8000;
    step(1'b0, 1'b1, 8'($urandom), first_b);
    for (int i = 1; i < 6; i++) step(1'b0, 1'b1, 8'($urandom), 16'($urandom));
    check("p6_first", 32'(if_b.output_data), 32'(first_b));
    repeat (6) step(1'b0, 1'b0, 8'($urandom), 16'($urandom));
    check("p6_period", 32'(if_b.output_data), 32'(first_b));

    // Random mix of load, rotate and occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 1'($urandom), 8'($urandom), 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/dff_link_4_circle.md
# dff_link_4_circle

Four-stage circular register chain (DFF ring) for 8-bit data. While `WR` is high, each clock shifts `input_data` into the head of the chain. While `WR` is low, the chain rotates: the tail stage feeds back into the head, so the stored words replay on `output_data` indefinitely. It serves as a small recirculating delay line / pattern replayer and is fed by an upstream counter or data source.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 4, number of register stages in the ring; must be ≥ 2.
- `CLK`  input  1  single clock; all state updates on its rising edge.
- `RST`  input  1  reset, synchronous, active-high; clears every stage.
- `input_data`  input  WIDTH  word loaded into the head stage when `WR`=1.
- `WR`  input  1  1 = shift-in mode; 0 = circulate mode.
- `output_data`  output  WIDTH  contents of the tail stage (stage DEPTH-1); a registered value with no combinational path from the inputs.

## Operation
- State: stages s[0] (head) … s[DEPTH-1] (tail), each WIDTH bits.
- Rising edge with `RST`=1: all s[i] ← 0. Reset has priority over `WR`.
- Rising edge with `RST`=0 and `WR`=1 (load):
  - s[0] ← `input_data`.
  - s[i] ← s[i-1] for i = 1..DEPTH-1.
  - The old tail value is discarded.
- Rising edge with `RST`=0 and `WR`=0 (circulate):
  - s[0] ← s[DEPTH-1].
  - s[i] ← s[i-1] for i = 1..DEPTH-1.
  - No data is lost; the contents rotate with period DEPTH.
- `output_data` = s[DEPTH-1] at all times.
- There is no hold mode: the chain advances on every non-reset edge.
- `WR` may toggle on any cycle.
  - A partial load (fewer than DEPTH writes) mixes the new words with the old contents. The ring then rotates whatever it holds.
- X/Z on `input_data` while `WR`=0 has no effect.

## Timing
- Reset value: `output_data` = 0 and all stages = 0 on the first edge with `RST`=1.
  - Deasserting `RST` mid-operation resumes from the all-zero state.
  - Asserting `RST` mid-rotation clears the ring at that edge.
- Load latency: a word written at edge n appears on `output_data` after edge n+DEPTH-1, i.e. DEPTH-1 edges after its own write edge, provided `WR` stays 1 or the chain keeps shifting.
- After DEPTH consecutive writes d0..d(DEPTH-1) on edges 1..DEPTH:
  - `output_data` = d0 after edge DEPTH.
  - If `WR`=0 from then on, `output_data` = d1, d2, …, d(DEPTH-1), d0, d1, … on successive edges.
- During the initial load from reset, `output_data` stays 0 for the first DEPTH-1 edges.
- Throughput: one shift per clock. There is no handshake or ready signal.

## Test plan
- Reset: hold `RST`=1 for 2 edges with `WR`=1 and `input_data`=8'hAA → `output_data`=0 and all stages 0.
- Load then circulate: release reset, then `WR`=1 for 4 edges with `input_data`=0,1,2,3 (counter-driven), then `WR`=0.
  - `output_data` = 0,0,0,0 after edges 1–4 (the 4th shows d0=0).
  - It then reads 1,2,3,0,1,2,3,… on following edges.
- Continuous write: `WR`=1 with `input_data` = 8'h10, 8'h11, 8'h12, … → `output_data` lags `input_data` by exactly 3 edges.
- Partial load: from a ring holding {A,B,C,D} (tail D), write one word 8'h55 with `WR`=1, then `WR`=0.
  - After the write edge, the ring holds s[0..3] = 8'h55, A, B, C.
  - `output_data` then rotates C, B, A, 8'h55, C, … on successive edges.
- Reset mid-rotation: while rotating values 1..4, assert `RST` for one edge → `output_data`=0 on that edge, and the ring stays all-zero while `WR`=0.
- Parameter check: WIDTH=16 and DEPTH=6 with a load of 6 words → replay period is 6, and the first word appears after the 6th write edge.
